// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: hazard/status inputs and pipeline-register controls
// exchanged between the pipeline datapath and the stall controller.
//   master : pipeline side; drives hazard/memory status, receives controls
//   slave  : controller side; receives status, drives write enables/bubbles
interface pipe_stall_ctrl_if;
   logic       IDEX_memread;
   logic [4:0] IDEX_rt;
   logic [4:0] IFID_rs;
   logic [4:0] IFID_rt;
   logic       branch_taken;
   logic       mem_req;
   logic       mem_ready;
   logic       PCWrite;
   logic       IFIDWrite;
   logic       IDEXWrite;
   logic       EXMEMWrite;
   logic       IFIDFlush;
   logic       IDEXBubble;
   logic       MEMWBBubble;

   modport master (
      output IDEX_memread, IDEX_rt, IFID_rs, IFID_rt,
             branch_taken, mem_req, mem_ready,
      input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
             IFIDFlush, IDEXBubble, MEMWBBubble
   );

   modport slave (
      input  IDEX_memread, IDEX_rt, IFID_rs, IFID_rt,
             branch_taken, mem_req, mem_ready,
      output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
             IFIDFlush, IDEXBubble, MEMWBBubble
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: prioritised stall/flush sequencer for the 5-stage MIPS
// pipe. Combines load-use stalls, taken-branch flushes and data-memory wait
// freezing; halts the pipe (sticky mem_err) if memory never answers.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   bus (slave)   hazard/memory status in, pipeline register controls out
//   mem_err       sticky memory-timeout error
//   ctrl_state    0 RUN, 1 MEMWAIT, 2 HALT
//   stall_cycles  saturating count of cycles with PCWrite=0
//   flush_count   saturating count of IF/ID flushes
// Parameter MEM_TIMEOUT (1..255): tolerated wait count before HALT.
// Macro PIPE_PERF_CNT_EN: builds the performance counters; when undefined
// stall_cycles/flush_count are tied to zero.
module pipe_stall_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pipe_stall_ctrl_if.slave       bus,
   output logic                   mem_err,
   output logic [1:0]             ctrl_state,
   output logic [31:0]            stall_cycles,
   output logic [15:0]            flush_count
);

   localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] TIMEOUT_V = WCW'(MEM_TIMEOUT);
   localparam logic [WCW-1:0] ONE_V     = WCW'(1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      HALT    = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
   logic           lu;
   logic           mem_stall;

   logic pc_write, ifid_write, idex_write, exmem_write;
   logic ifid_flush, idex_bubble, memwb_bubble, err;

   // Register $0 is hard-wired zero, so a load targeting it never stalls.
   assign lu = bus.IDEX_memread && (bus.IDEX_rt != 5'd0) &&
               ((bus.IDEX_rt == bus.IFID_rs) || (bus.IDEX_rt == bus.IFID_rt));
   assign mem_stall = bus.mem_req && !bus.mem_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      unique case (state)
         RUN: begin
            if (mem_stall) begin
               state_nxt    = MEMWAIT;
               wait_cnt_nxt = ONE_V;
            end
         end
         MEMWAIT: begin
            // Once in MEMWAIT only mem_ready matters; mem_req is not re-checked.
            if (bus.mem_ready) begin
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == TIMEOUT_V) begin
               state_nxt = HALT;
            end else begin
               wait_cnt_nxt = wait_cnt + ONE_V;
            end
         end
         HALT: begin
            state_nxt = HALT;
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      exmem_write  = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      memwb_bubble = 1'b0;
      err          = 1'b0;
      if (!rst_n) begin
         // Hold the pipe inert while reset is asserted.
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_write  = 1'b0;
         idex_bubble  = 1'b1;
         memwb_bubble = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               if (mem_stall) begin
                  pc_write     = 1'b0;
                  ifid_write   = 1'b0;
                  idex_write   = 1'b0;
                  exmem_write  = 1'b0;
                  memwb_bubble = 1'b1;
               end else if (bus.branch_taken) begin
                  // Flushing ID also kills any load-use dependent, so no stall.
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
               end else if (lu) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
               end
            end
            MEMWAIT: begin
               if (!bus.mem_ready) begin
                  pc_write     = 1'b0;
                  ifid_write   = 1'b0;
                  idex_write   = 1'b0;
                  exmem_write  = 1'b0;
                  memwb_bubble = 1'b1;
               end
            end
            default: begin
               pc_write     = 1'b0;
               ifid_write   = 1'b0;
               idex_write   = 1'b0;
               exmem_write  = 1'b0;
               memwb_bubble = 1'b1;
               err          = 1'b1;
            end
         endcase
      end
   end

   assign bus.PCWrite     = pc_write;
   assign bus.IFIDWrite   = ifid_write;
   assign bus.IDEXWrite   = idex_write;
   assign bus.EXMEMWrite  = exmem_write;
   assign bus.IFIDFlush   = ifid_flush;
   assign bus.IDEXBubble  = idex_bubble;
   assign bus.MEMWBBubble = memwb_bubble;
   assign mem_err         = err;
   assign ctrl_state      = state;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_q;
   logic [15:0] flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_write && (stall_q != '1))
            stall_q <= stall_q + 32'd1;
         if (ifid_flush && (flush_q != '1))
            flush_q <= flush_q + 16'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule
